// File: rtl/tmr_word_voter.sv
// Triple-modular-redundancy word voter with per-lane fault isolation.
// Degrades TMR -> DMR -> SIMPLEX -> FAILED as lanes accumulate consecutive disagreements.
module tmr_word_voter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clr_fault,
  input  logic [1:0]       err_cnt_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             mismatch,
  output logic [2:0]       lane_err,
  output logic [2:0]       lane_fault,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] MODE_TMR     = 2'd0;
  localparam logic [1:0] MODE_DMR     = 2'd1;
  localparam logic [1:0] MODE_SIMPLEX = 2'd2;
  localparam logic [1:0] MODE_FAILED  = 2'd3;

  logic [2:0][WIDTH-1:0] lanes;
  logic [WIDTH-1:0]      maj;
  logic [1:0]            lo_idx, hi_idx;

  logic [WIDTH-1:0]      vote_y;
  logic                  vote_mis;
  logic [2:0]            vote_err;

  logic                  out_valid_q;
  logic [WIDTH-1:0]      y_q;
  logic                  mismatch_q;
  logic [2:0]            lane_err_q;
  logic [2:0]            fault_q, fault_d;
  logic [1:0]            mode_q, mode_d;
  logic [2:0][7:0]       cons_q, cons_d;
  logic [2:0][CNT_W-1:0] tot_q, tot_d;

  assign lanes = {c, b, a};
  assign maj   = (a & b) | (b & c) | (a & c);

  // lo_idx = lowest healthy lane, hi_idx = highest; equal in SIMPLEX
  always_comb begin
    lo_idx = 2'd0;
    hi_idx = 2'd0;
    for (int unsigned i = 3; i > 0; i--) begin
      if (!fault_q[i-1]) lo_idx = 2'(i-1);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      if (!fault_q[i]) hi_idx = 2'(i);
    end
  end

  always_comb begin
    vote_y   = maj;
    vote_mis = 1'b0;
    vote_err = '0;
    case (mode_q)
      MODE_TMR: begin
        for (int unsigned i = 0; i < 3; i++) vote_err[i] = (lanes[i] != maj);
        vote_mis = |vote_err;
      end
      MODE_DMR: begin
        vote_y   = lanes[lo_idx];
        vote_mis = (lanes[lo_idx] != lanes[hi_idx]);
      end
      MODE_SIMPLEX: vote_y = lanes[lo_idx];
      MODE_FAILED:  vote_mis = !((a == b) && (b == c));
      default: ;
    endcase
  end

  // Fault accounting runs only in TMR, where every lane is still healthy
  always_comb begin
    cons_d  = cons_q;
    tot_d   = tot_q;
    fault_d = fault_q;
    if (in_valid && (mode_q == MODE_TMR)) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (vote_err[i]) begin
          cons_d[i] = cons_q[i] + 8'd1;
          if (tot_q[i] != '1) tot_d[i] = tot_q[i] + CNT_W'(1);
          if (cons_d[i] == 8'(FAULT_THRESH)) fault_d[i] = 1'b1;
        end else begin
          cons_d[i] = '0;
        end
      end
    end
    mode_d = 2'(fault_d[0]) + 2'(fault_d[1]) + 2'(fault_d[2]);
    if (clr_fault) begin
      cons_d  = '0;
      tot_d   = '0;
      fault_d = '0;
      mode_d  = MODE_TMR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      mismatch_q  <= 1'b0;
      lane_err_q  <= '0;
      fault_q     <= '0;
      mode_q      <= MODE_TMR;
      cons_q      <= '0;
      tot_q       <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        y_q        <= vote_y;
        mismatch_q <= vote_mis;
        lane_err_q <= vote_err;
      end else begin
        mismatch_q <= 1'b0;
        lane_err_q <= '0;
      end
      fault_q <= fault_d;
      mode_q  <= mode_d;
      cons_q  <= cons_d;
      tot_q   <= tot_d;
    end
  end

  always_comb begin
    case (err_cnt_sel)
      2'd0:    err_cnt = tot_q[0];
      2'd1:    err_cnt = tot_q[1];
      2'd2:    err_cnt = tot_q[2];
      default: err_cnt = '0;
    endcase
  end

  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign mismatch   = mismatch_q;
  assign lane_err   = lane_err_q;
  assign lane_fault = fault_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_tmr_word_voter.sv
// Directed bench for tmr_word_voter: voting, fault isolation, mode degradation, clear and reset.
module tb_tmr_word_voter;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr_fault;
  logic [7:0] a, b, c;
  logic [1:0] err_cnt_sel;
  logic       out_valid, mismatch;
  logic [7:0] y, err_cnt;
  logic [2:0] lane_err, lane_fault;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmr_word_voter #(.WIDTH(8), .FAULT_THRESH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .clr_fault(clr_fault), .err_cnt_sel(err_cnt_sel), .out_valid(out_valid),
    .y(y), .mismatch(mismatch), .lane_err(lane_err), .lane_fault(lane_fault),
    .mode(mode), .err_cnt(err_cnt)
  );

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge
  task automatic drive(input logic v, input logic [7:0] va, vb, vc, input logic clr);
    in_valid = v; a = va; b = vb; c = vc; clr_fault = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_fault = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    rst = 1'b0;
    checks++; if (y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h exp=00", y); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++; if (lane_fault !== 3'b000) begin failures++; $display("FAIL reset_fault got=%b exp=000", lane_fault); end
  endtask

  task automatic test_all_equal();
    drive(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    checks++; if (y !== 8'hA5) begin failures++; $display("FAIL eq_y got=%h exp=a5", y); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL eq_ov got=%b exp=1", out_valid); end
    checks++; if (mismatch !== 1'b0 || lane_err !== 3'b000) begin
      failures++; $display("FAIL eq_err got=%b/%b exp=0/000", mismatch, lane_err); end
    drive(1'b0, 8'h00, 8'h11, 8'h22, 1'b0);
    checks++; if (out_valid !== 1'b0 || y !== 8'hA5) begin
      failures++; $display("FAIL idle_hold got=%b/%h exp=0/a5", out_valid, y); end
  endtask

  task automatic test_single_fault();
    // 3 disagreements, one agreement (clears the run), then 4 more to trip the threshold
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b0);
    drive(1'b1, 8'h0F, 8'h0F, 8'h0F, 1'b0);
    checks++; if (lane_fault !== 3'b000 || mode !== 2'd0) begin
      failures++; $display("FAIL run_cleared got=%b/%0d exp=000/0", lane_fault, mode); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b0);
      checks++; if (y !== 8'h0F || lane_err !== 3'b001 || mismatch !== 1'b1) begin
        failures++; $display("FAIL sf_vote%0d got=%h/%b/%b exp=0f/001/1", i, y, lane_err, mismatch); end
      if (i == 2) begin
        checks++; if (lane_fault !== 3'b000) begin failures++; $display("FAIL sf_early got=%b exp=000", lane_fault); end
      end
    end
    checks++; if (lane_fault !== 3'b001 || mode !== 2'd1) begin
      failures++; $display("FAIL sf_dmr got=%b/%0d exp=001/1", lane_fault, mode); end
    err_cnt_sel = 2'd0; #1;
    checks++; if (err_cnt !== 8'd7) begin failures++; $display("FAIL sf_cnt0 got=%0d exp=7", err_cnt); end
    err_cnt_sel = 2'd3; #1;
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL sf_cnt3 got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_dmr();
    drive(1'b1, 8'h00, 8'h11, 8'h22, 1'b0);
    checks++; if (y !== 8'h11 || mismatch !== 1'b1 || lane_err !== 3'b000) begin
      failures++; $display("FAIL dmr_diff got=%h/%b/%b exp=11/1/000", y, mismatch, lane_err); end
    drive(1'b1, 8'h00, 8'h33, 8'h33, 1'b0);
    checks++; if (y !== 8'h33 || mismatch !== 1'b0) begin
      failures++; $display("FAIL dmr_agree got=%h/%b exp=33/0", y, mismatch); end
    err_cnt_sel = 2'd0; #1;
    checks++; if (err_cnt !== 8'd7) begin failures++; $display("FAIL dmr_cnt0 got=%0d exp=7", err_cnt); end
    err_cnt_sel = 2'd2; #1;
    checks++; if (err_cnt !== 8'd0 || mode !== 2'd1) begin
      failures++; $display("FAIL dmr_cnt2 got=%0d/%0d exp=0/1", err_cnt, mode); end
  endtask

  task automatic test_clear_with_vote();
    drive(1'b1, 8'h00, 8'h11, 8'h22, 1'b1);
    checks++; if (y !== 8'h11 || mismatch !== 1'b1 || lane_err !== 3'b000) begin
      failures++; $display("FAIL clr_vote got=%h/%b/%b exp=11/1/000", y, mismatch, lane_err); end
    checks++; if (mode !== 2'd0 || lane_fault !== 3'b000) begin
      failures++; $display("FAIL clr_state got=%0d/%b exp=0/000", mode, lane_fault); end
    for (int s = 0; s < 3; s++) begin
      err_cnt_sel = 2'(s); #1;
      checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL clr_cnt%0d got=%0d exp=0", s, err_cnt); end
    end
  endtask

  task automatic test_triple_fault();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h01, 8'h02, 8'h04, 1'b0);
      checks++; if (y !== 8'h00 || lane_err !== 3'b111) begin
        failures++; $display("FAIL tf_vote%0d got=%h/%b exp=00/111", i, y, lane_err); end
    end
    checks++; if (lane_fault !== 3'b111 || mode !== 2'd3) begin
      failures++; $display("FAIL tf_failed got=%b/%0d exp=111/3", lane_fault, mode); end
    drive(1'b1, 8'h5A, 8'h5A, 8'h00, 1'b0);
    checks++; if (y !== 8'h5A || mismatch !== 1'b1 || lane_err !== 3'b000) begin
      failures++; $display("FAIL failed_vote got=%h/%b/%b exp=5a/1/000", y, mismatch, lane_err); end
    err_cnt_sel = 2'd1; #1;
    checks++; if (err_cnt !== 8'd4) begin failures++; $display("FAIL failed_cnt1 got=%0d exp=4", err_cnt); end
  endtask

  task automatic test_double_jump();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    // majority of F0/0F/FF is FF, so lanes 0 and 1 disagree together
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hF0, 8'h0F, 8'hFF, 1'b0);
    checks++; if (y !== 8'hFF || lane_err !== 3'b011) begin
      failures++; $display("FAIL dj_vote got=%h/%b exp=ff/011", y, lane_err); end
    checks++; if (lane_fault !== 3'b011 || mode !== 2'd2) begin
      failures++; $display("FAIL dj_simplex got=%b/%0d exp=011/2", lane_fault, mode); end
    drive(1'b1, 8'h00, 8'h00, 8'h3C, 1'b0);
    checks++; if (y !== 8'h3C || mismatch !== 1'b0 || lane_err !== 3'b000) begin
      failures++; $display("FAIL simplex_vote got=%h/%b/%b exp=3c/0/000", y, mismatch, lane_err); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    drive(1'b1, 8'h77, 8'h77, 8'h77, 1'b0);
    rst = 1'b0;
    checks++; if (y !== 8'h00 || out_valid !== 1'b0 || mismatch !== 1'b0 || lane_err !== 3'b000) begin
      failures++; $display("FAIL rstmid_out got=%h/%b/%b/%b exp=00/0/0/000", y, out_valid, mismatch, lane_err); end
    checks++; if (lane_fault !== 3'b000 || mode !== 2'd0) begin
      failures++; $display("FAIL rstmid_state got=%b/%0d exp=000/0", lane_fault, mode); end
    err_cnt_sel = 2'd0; #1;
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", err_cnt); end
    drive(1'b1, 8'h12, 8'h12, 8'h12, 1'b0);
    checks++; if (y !== 8'h12 || out_valid !== 1'b1) begin
      failures++; $display("FAIL post_rst got=%h/%b exp=12/1", y, out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clr_fault = 1'b0;
    a = '0; b = '0; c = '0; err_cnt_sel = 2'd0;
    test_reset();
    test_all_equal();
    test_single_fault();
    test_dmr();
    test_clear_with_vote();
    test_triple_fault();
    test_double_jump();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
